// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // ecall encoding; fetching stops after this word is pushed
  localparam logic [31:0] HALT_WORD = 32'h0000_0073;

  // Byte distance between consecutive instruction words
  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/instr_buf.sv
// Two-entry FIFO of {pc, instr} pairs feeding the decode stage.
// Flush empties the FIFO; the stored data is left in place but is never
// presented as valid again.
module instr_buf #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ADDRESS_WIDTH-1:0] push_pc,
  input  logic [DATA_WIDTH-1:0]    push_instr,
  input  logic                     pop,
  input  logic                     flush,
  output logic [1:0]               count,
  output logic                     valid,
  output logic [ADDRESS_WIDTH-1:0] head_pc,
  output logic [DATA_WIDTH-1:0]    head_instr
);

  logic [ADDRESS_WIDTH-1:0] pc_mem    [2];
  logic [DATA_WIDTH-1:0]    instr_mem [2];
  logic                     rd_ptr_reg;
  logic                     wr_ptr_reg;
  logic [1:0]               count_reg;
  logic                     do_push;
  logic                     do_pop;

  // Flush wins over everything; a push into a full FIFO needs a pop alongside it
  assign do_pop  = pop && !flush && (count_reg != 2'd0);
  assign do_push = push && !flush && ((count_reg != 2'd2) || do_pop);

  // Entry storage, one register pair per slot
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          pc_mem[gi]    <= '0;
          instr_mem[gi] <= '0;
        end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
          pc_mem[gi]    <= push_pc;
          instr_mem[gi] <= push_instr;
        end
      end
    end
  endgenerate

  // Read/write pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + 2'(do_push) - 2'(do_pop);
    end
  end

  assign count      = count_reg;
  assign valid      = (count_reg != 2'd0);
  assign head_pc    = pc_mem[rd_ptr_reg];
  assign head_instr = instr_mem[rd_ptr_reg];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the asynchronous ROM
// address, buffers fetched words and stops after an ecall until redirected.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                    ADDRESS_WIDTH = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD     = DATA_WIDTH'(fetch_pkg::HALT_WORD)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic [ADDRESS_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0]    RD,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr_out,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic                     halted,
  output logic [31:0]              fetch_count
);

  fetch_state_t             state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0] pc_reg, pc_next;
  logic [31:0]              fetch_count_reg;
  logic [1:0]               buf_count;
  logic                     pop;
  logic                     fire;

  assign pop  = instr_valid && instr_ready;
  // A fetch needs room in the buffer, counting the slot freed by a same-cycle pop
  assign fire = (state_reg == FETCH) && en && !redirect &&
                ((buf_count != 2'd2) || pop);

  instr_buf #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (fire),
    .push_pc   (pc_reg),
    .push_instr(RD),
    .pop       (pop),
    .flush     (redirect),
    .count     (buf_count),
    .valid     (instr_valid),
    .head_pc   (instr_pc),
    .head_instr(instr_out)
  );

  // Next state and next PC; redirect overrides fetch and halt
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    if (redirect) begin
      state_next = en ? FETCH : IDLE;
      pc_next    = redirect_pc & ~ADDRESS_WIDTH'(3);
    end else begin
      unique case (state_reg)
        IDLE:    if (en) state_next = FETCH;
        FETCH: begin
          if (!en) begin
            state_next = IDLE;
          end else if (fire) begin
            pc_next = pc_reg + ADDRESS_WIDTH'(PC_INC);
            if (RD == HALT_WORD) state_next = HALTED;
          end
        end
        HALTED:  state_next = HALTED;
        default: state_next = IDLE;
      endcase
    end
  end

  // State, PC and fetch counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      fetch_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (fire) fetch_count_reg <= fetch_count_reg + 32'd1;
    end
  end

  assign A           = pc_reg;
  assign halted      = (state_reg == HALTED);
  assign fetch_count = fetch_count_reg;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that drives the address port of the asynchronous instruction ROM and delivers instructions downstream through a valid/ready interface. Holds the program counter, a 2-entry instruction buffer, branch-redirect handling and halt detection. Sits between `instr_mem` and the decode/control stage of the reduced RISC-V core.

## Interface
- `ADDRESS_WIDTH`, 32, PC / ROM address width
- `DATA_WIDTH`, 32, instruction width
- `RESET_PC`, 0, PC value after reset
- `HALT_WORD`, 32'h00000073, instruction encoding that stops fetching (ecall)

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `en`  in  1  fetch enable
- `A`  out  ADDRESS_WIDTH  ROM address, equals current PC (combinational)
- `RD`  in  DATA_WIDTH  ROM read data, valid in the same cycle as `A`
- `redirect`  in  1  branch/jump taken, one-cycle pulse
- `redirect_pc`  in  ADDRESS_WIDTH  redirect target
- `instr_valid`  out  1  buffer head holds an instruction
- `instr_ready`  in  1  downstream accepts head
- `instr_out`  out  DATA_WIDTH  head instruction
- `instr_pc`  out  ADDRESS_WIDTH  PC of head instruction
- `halted`  out  1  high while in HALTED
- `fetch_count`  out  32  number of words pushed into the buffer since reset

## Operation
- States: IDLE, FETCH, HALTED. Reset -> IDLE.
- IDLE: no fetch. `en`=1 -> FETCH next cycle.
- FETCH: fetch fires when `en`=1 and (count<2 or pop this cycle). Fire: push {PC, `RD`} at buffer tail, PC <= PC+4 (wraps modulo 2^ADDRESS_WIDTH), `fetch_count` +1 (wraps).
- FETCH, `en`=0: no fetch that cycle; -> IDLE. Buffer contents retained and still drained.
- Fire with `RD`==HALT_WORD: word is pushed normally, PC advances, -> HALTED.
- HALTED: no fetch; buffer still drains; `halted`=1. Leaves only on reset or redirect.
- Pop: `instr_valid` && `instr_ready`; head removed at clock edge.
- Buffer: 2-entry FIFO, count 0..2; push+pop same cycle when full is legal, count unchanged.
- Redirect (any state): buffer flushed (count <= 0), PC <= `redirect_pc` with bits [1:0] forced to 0, no fetch that cycle, state -> FETCH if `en`=1 else IDLE. Redirect overrides fetch, halt and any push; a coincident pop is considered accepted by downstream and is also flushed.
- `rst` overrides everything, including redirect.

## Timing
- Reset values: PC=RESET_PC (so `A`=RESET_PC), count=0, `instr_valid`=0, `instr_out`=0, `instr_pc`=0, `halted`=0, `fetch_count`=0, state IDLE.
- `A` combinational from PC; `RD` sampled in the same cycle (ROM is asynchronous).
- Fetch-to-valid latency: 1 cycle (word fetched in cycle N is at head in N+1 if buffer was empty).
- Sustained throughput 1 instr/cycle with `instr_ready` held high.
- First fetch: cycle after `en` rises in IDLE (IDLE->FETCH transition cycle does not fetch).
- Redirect in cycle N: `instr_valid`=0 in N+1; first target word fetched in N+1, valid in N+2.
- `instr_out`/`instr_pc` stable while `instr_valid`=1 and `instr_ready`=0.

## Structure
- Shared package `fetch_pkg`: state enum `fetch_state_t` {IDLE, FETCH, HALTED}, `HALT_WORD` constant, PC increment constant 4.
- Sub-module `instr_buf`: 2-entry FIFO of {pc, instr} with push/pop/flush, count, head outputs. FSM, PC and counter in `fetch_ctrl`.

## Test plan
- Reset, `en`=1, ROM 0x00500093,0x00108113,..., `instr_ready`=1 -> `A`=0,4,8 on consecutive cycles; `instr_pc`=0 with `instr_out`=0x00500093 two cycles after `en` rises; `fetch_count` increments each cycle.
- `instr_ready`=0 from start -> exactly 2 words fetched, `A` holds 8, `instr_pc` stays 0; raise ready -> resumes with no word lost or duplicated.
- Redirect to 0x103 while buffer full -> next cycle `instr_valid`=0, `A`=0x100; head two cycles later has `instr_pc`=0x100.
- HALT_WORD at address 0xC -> words 0..0xC delivered, `halted`=1, `A` holds 0x10, `fetch_count`=4; redirect to 0 -> `halted`=0, fetching resumes.
- PC=2^32-4, fetch -> `A` wraps to 0; `fetch_count` at 0xFFFFFFFF wraps to 0.
- Assert `rst` mid-stream with buffer full and redirect pending -> next cycle all outputs at reset values, state IDLE.
